// File: rtl/lucas_seq_gen.sv
// Second-order recurrence generator a(n+2) = P*a(n+1) + Q*a(n), streamed on a
// valid/ready port until the next term would exceed N bits or the index caps.
module lucas_seq_gen #(
  parameter int N    = 13,
  parameter int CW   = 2,
  parameter int IDXW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CW-1:0]   p,
  input  logic [CW-1:0]   q,
  input  logic [N-1:0]    seed0,
  input  logic [N-1:0]    seed1,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int WW = N + CW + 1;
  localparam logic [WW-1:0]   MAX     = {{(CW+1){1'b0}}, {N{1'b1}}};
  localparam logic [IDXW-1:0] IDX_CAP = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   p_r, q_r;
  logic [N-1:0]    term, next;
  logic            next_ovf;
  logic [IDXW-1:0] idx;
  logic [WW-1:0]   nxt2;
  logic            last, fire, load;

  // Wide enough that P*next + Q*term can never wrap, so overflow is a plain compare.
  always_comb begin
    nxt2 = WW'(p_r) * WW'(next) + WW'(q_r) * WW'(term);
  end

  assign last     = next_ovf || (idx == IDX_CAP);
  assign fire     = (state == RUN) && out_ready;
  assign out_data = term;
  assign out_idx  = idx;

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = last;
        if (fire && last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      p_r      <= '0;
      q_r      <= '0;
      term     <= '0;
      next     <= '0;
      next_ovf <= 1'b0;
      idx      <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        p_r      <= p;
        q_r      <= q;
        term     <= seed0;
        next     <= seed1;
        next_ovf <= 1'b0;
        idx      <= '0;
      end else if (fire && !last) begin
        term     <= next;
        idx      <= idx + 1'b1;
        next     <= nxt2[N-1:0];
        next_ovf <= (nxt2 > MAX);
      end
    end
  end

endmodule

// File: tb/tb_lucas_seq_gen.sv
// Bench for lucas_seq_gen: directed and random runs against an arithmetic model.
module tb_lucas_seq_gen;
  localparam int N    = 13;
  localparam int CW   = 2;
  localparam int IDXW = 6;
  localparam longint MAXV = (longint'(1) << N) - 1;
  localparam int CAP = 1 << IDXW;

  logic            clk = 1'b0;
  logic            reset, start, out_ready;
  logic [CW-1:0]   p, q;
  logic [N-1:0]    seed0, seed1;
  logic            out_valid, out_last, busy, done;
  logic [N-1:0]    out_data;
  logic [IDXW-1:0] out_idx;

  int total = 0;
  int bad   = 0;
  int stall_bad;
  longint          exp_q[$];
  logic [N-1:0]    got_d[$];
  logic [IDXW-1:0] got_i[$];
  logic            got_l[$];

  always #5 clk = ~clk;

  lucas_seq_gen #(.N(N), .CW(CW), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .q(q),
    .seed0(seed0), .seed1(seed1), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Terms of the recurrence that fit in N bits, at most CAP of them.
  task automatic build_model(input int pp, input int qq, input longint s0, input longint s1);
    longint a, b, c;
    exp_q.delete();
    exp_q.push_back(s0);
    exp_q.push_back(s1);
    a = s0;
    b = s1;
    while (exp_q.size() < CAP) begin
      c = pp * b + qq * a;
      if (c > MAXV) break;
      exp_q.push_back(c);
      a = b;
      b = c;
    end
  endtask

  // Called at a negedge; records transferred beats and returns at the negedge after the last one.
  task automatic collect(input int budget, input bit rnd, input bit inject, output bit tmo);
    int stall = 0;
    bit fin = 1'b0;
    bit held = 1'b0;
    logic [N-1:0] hd;
    logic [IDXW-1:0] hi;
    logic hl;
    got_d.delete(); got_i.delete(); got_l.delete();
    stall_bad = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      start = 1'b0;
      if (held && (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi || out_last !== hl))
        stall_bad++;
      held = 1'b0;
      if (!rnd) out_ready = 1'b1;
      else if (stall > 0) begin out_ready = 1'b0; stall--; end
      else if ($urandom_range(0, 7) == 0) begin out_ready = 1'b0; stall = 4; end
      else out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_i.push_back(out_idx);
        got_l.push_back(out_last);
        if (out_last) fin = 1'b1;
        if (inject && out_idx == 4) begin
          start = 1'b1; p = 2'd3; q = 2'd3; seed0 = N'(77); seed1 = N'(99);
        end
      end else if (out_valid) begin
        held = 1'b1; hd = out_data; hi = out_idx; hl = out_last;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    tmo = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    p = '0; q = '0; seed0 = '0; seed1 = '0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL reset_valid_last: got %b/%b want 0/0", out_valid, out_last);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done);
    end
    total++;
    if (out_data !== '0 || out_idx !== '0) begin
      bad++; $display("FAIL reset_data_idx: got %0d/%0d want 0/0", out_data, out_idx);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream(input string name, input int pp, input int qq,
                             input longint s0, input longint s1, input bit rnd, input bit inject);
    bit tmo;
    int n;
    build_model(pp, qq, s0, s1);
    p = CW'(pp); q = CW'(qq); seed0 = N'(s0); seed1 = N'(s1);
    out_ready = 1'b0;
    start = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL %s pre_start_valid: got %b want 0", name, out_valid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== N'(s0) || out_idx !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s first_beat: got v=%b d=%0d i=%0d busy=%b want v=1 d=%0d i=0 busy=1",
                      name, out_valid, out_data, out_idx, busy, s0);
    end
    collect(4000, rnd, inject, tmo);
    total++;
    if (tmo) begin
      bad++; $display("FAIL %s timeout: got no last beat want last within budget", name);
    end
    total++;
    if (got_d.size() != exp_q.size()) begin
      bad++; $display("FAIL %s beat_count: got %0d want %0d", name, got_d.size(), exp_q.size());
    end
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_d[i] !== N'(exp_q[i]) || got_i[i] !== IDXW'(i) || got_l[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL %s beat %0d: got d=%0d i=%0d last=%b want d=%0d i=%0d last=%b",
                        name, i, got_d[i], got_i[i], got_l[i], exp_q[i], i, (i == exp_q.size() - 1));
      end
    end
    total++;
    if (stall_bad !== 0) begin
      bad++; $display("FAIL %s stall_stability: got %0d changes want 0", name, stall_bad);
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== N'(exp_q[exp_q.size() - 1])) begin
      bad++; $display("FAIL %s done_state: got done=%b v=%b busy=%b d=%0d want 1/0/0/%0d",
                      name, done, out_valid, busy, out_data, exp_q[exp_q.size() - 1]);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    p = 2'd1; q = 2'd1; seed0 = '0; seed1 = N'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (c < 50 && out_idx != IDXW'(7)) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (out_idx !== IDXW'(7)) begin
      bad++; $display("FAIL reset_mid_reach: got idx %0d want 7", out_idx);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 || out_last !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got v=%b busy=%b idx=%0d last=%b done=%b want 0/0/0/0/0",
                      out_valid, busy, out_idx, out_last, done);
    end
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream("fib", 1, 1, 0, 1, 1'b0, 1'b0);
    test_stream("pell", 2, 1, 0, 1, 1'b0, 1'b0);
    test_stream("fib_backpressure", 1, 1, 0, 1, 1'b1, 1'b0);
    test_stream("zero_coeff", 0, 0, 3, 5, 1'b0, 1'b0);
    test_reset_mid();
    test_stream("fib_after_reset", 1, 1, 0, 1, 1'b0, 1'b0);
    test_stream("fib_start_in_run", 1, 1, 0, 1, 1'b1, 1'b1);
    test_stream("lucas", 1, 1, 2, 1, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      test_stream("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  longint'($urandom_range(0, 8191)), longint'($urandom_range(0, 8191)), 1'b1, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lucas_seq_gen.md
Name: lucas_seq_gen

Overview:
- Parametrised second-order recurrence generator: a(n+2) = P*a(n+1) + Q*a(n).
- Seeds a0 and a1 and the coefficients P and Q are loaded at start, so the same block produces Fibonacci, Lucas, Pell and Jacobsthal sequences.
- Terms are streamed on a valid/ready output. The stream ends on the last term that fits in N bits, or when the index counter saturates.
- Used as a lab-level number source feeding display and checker blocks.

Parameters:
- N, 13, term width in bits. MAX = 2^N-1.
- CW, 2, width of the coefficients P and Q.
- IDXW, 6, width of the term index. The index cap is 2^IDXW-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; loads the configuration and begins a run.
- p  input  CW  coefficient P, sampled on an accepted start.
- q  input  CW  coefficient Q, sampled on an accepted start.
- seed0  input  N  a0, sampled on an accepted start.
- seed1  input  N  a1, sampled on an accepted start.
- out_ready  input  1  consumer ready.
- out_valid  output  1  out_data is a valid term.
- out_data  output  N  current term a(idx).
- out_idx  output  IDXW  index of the current term.
- out_last  output  1  the current term is the final term of the run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset, synchronous to clk:
  - state = IDLE.
  - out_valid, out_last, busy, done = 0.
  - out_data = 0, out_idx = 0.
  - Internal term, next and next_ovf = 0.
- State IDLE:
  - out_valid = 0.
  - When start = 1, capture p, q, seed0 and seed1. Set term = seed0, next = seed1, next_ovf = 0, idx = 0. Go to RUN.
- State DONE:
  - done = 1, out_valid = 0.
  - start behaves as in IDLE and begins a new run. out_data and out_idx hold the last emitted beat.
- Start in RUN: ignored.
- Latency: start sampled at edge t gives out_valid = 1 with a0 after edge t; a0 is visible in the following cycle.
- RUN outputs:
  - out_valid = 1, busy = 1.
  - out_data = term, out_idx = idx.
  - out_last = next_ovf OR (idx == 2^IDXW-1).
- Transfer: a beat transfers when out_valid && out_ready.
- No transfer: term, idx, out_last and all outputs hold stable. Nothing advances under backpressure.
- Transfer with out_last = 0:
  - term <= next, idx <= idx+1.
  - next <= nxt2[N-1:0].
  - next_ovf <= (nxt2 > MAX).
- Transfer with out_last = 1: go to DONE, with out_valid = 0 in the next cycle.
- Arithmetic:
  - nxt2 = p*next + q*term, computed at N+CW+1 bits unsigned; this width never wraps.
  - Overflow is a compare against MAX, not a carry-out of N bits.
  - No term > MAX is ever emitted.
- Seeds always fit in N bits, so a0 and a1 are always emitted unless the index cap ends the run first.
- Degenerate coefficients: P = Q = 0 is legal and yields a0, a1, 0, 0, …. The run then terminates by the index cap.
- A run emits at most 2^IDXW terms. out_idx never wraps.
- Reset mid-run: returns to IDLE on the next edge. Any partial transfer is discarded, and no out_last is produced.
- Throughput: one term per cycle while out_ready = 1. The next-term computation is registered, so there is no combinational path from out_ready to out_data.

Test Plan:
1. N=13, p=1, q=1, seeds 0/1, out_ready=1 → 21 beats 0, 1, 1, 2, …, 4181, 6765. out_last only on idx 20 (6765), since 10946 > 8191. Then done=1; out_valid first high the cycle after start.
2. p=2, q=1, seeds 0/1 (Pell) → 0, 1, 2, 5, 12, 29, 70, 169, 408, 985, 2378, 5741. out_last at idx 11, since 13860 > 8191.
3. Fibonacci run with out_ready toggled pseudo-randomly (including 5-cycle stalls) → identical 21-term sequence. out_data, out_idx and out_last stable during every stall; exactly one transfer per accepted beat.
4. p=0, q=0, seeds 3/5, IDXW=6 → 3, 5, then 62 zeros. out_last at idx 63, 64 beats in total, then DONE.
5. Reset asserted at idx 7 of a Fibonacci run → next cycle out_valid=0, busy=0, out_idx=0. A following start restarts from a0=0.
6. Start pulsed at idx 4 of a run → ignored, sequence continues. A start in DONE with seeds 2/1 (Lucas) → 2, 1, 3, 4, 7, …, 5778. out_last at idx 18, since 9349 > 8191.
